// File: rtl/alu_shift_seq_if.sv
// alu_shift_seq_if: request/response bundle for the multi-bit shift sequencer.
// The master side issues shift requests and consumes results; the slave side
// is the sequencer itself. Both handshakes follow valid/ready semantics.
interface alu_shift_seq_if #(
   parameter int data_width = 16,
   parameter int amt_width  = 5
);

   // Request channel
   logic                  in_valid;
   logic                  in_ready;
   logic [data_width-1:0] in_a;
   logic [amt_width-1:0]  in_amt;
   logic [3:0]            in_func;

   // Response channel
   logic                  out_valid;
   logic                  out_ready;
   logic [data_width-1:0] out_c;
   logic                  out_overflow;

   modport master (
      output in_valid,
      output in_a,
      output in_amt,
      output in_func,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_c,
      input  out_overflow
   );

   modport slave (
      input  in_valid,
      input  in_a,
      input  in_amt,
      input  in_func,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_c,
      output out_overflow
   );

endinterface

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-bit shift sequencer feeding the single-bit ALU shift
// stage. A request (operand, amount, FuncCode) is latched, the one-bit shift
// is applied once per cycle on a working register for min(amount, width)
// cycles, and the result plus an error flag is offered downstream.
//
// Optional feature macro: ALU_SHIFT_ALS_OVF_EN
//   defined   : ALS steps that change the sign bit set a sticky overflow flag
//   undefined : only an unsupported FuncCode raises the flag
module alu_shift_seq #(
   parameter int data_width = 16,
   parameter int amt_width  = 5
) (
   input logic         clk,
   input logic         reset,
   alu_shift_seq_if.slave bus
);

   // FuncCodes understood by the downstream shift stage
   localparam logic [3:0] func_lls = 4'b0100;
   localparam logic [3:0] func_lrs = 4'b0101;
   localparam logic [3:0] func_als = 4'b0110;
   localparam logic [3:0] func_ars = 4'b0111;

   // The counter must hold data_width itself, since larger amounts clamp to it
   localparam int cnt_w = $clog2(data_width + 1);
   localparam int cmp_w = (amt_width > cnt_w) ? amt_width : cnt_w;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                state;
   state_t                state_next;

   logic [data_width-1:0] work;
   logic [data_width-1:0] work_next;
   logic [cnt_w-1:0]      count;
   logic [cnt_w-1:0]      count_next;
   logic [3:0]            func;
   logic [3:0]            func_next;
   logic                  ovf;
   logic                  ovf_next;

   logic [data_width-1:0] shifted;
   logic [cmp_w-1:0]      amt_ext;
   logic [cnt_w-1:0]      amt_clamped;
   logic                  func_ok;

   // Both sides widened to a common width so the clamp compare is exact
   assign amt_ext     = cmp_w'(bus.in_amt);
   assign amt_clamped = (amt_ext >= cmp_w'(data_width)) ? cnt_w'(data_width)
                                                         : cnt_w'(amt_ext);

   assign func_ok = (bus.in_func == func_lls) || (bus.in_func == func_lrs) ||
                    (bus.in_func == func_als) || (bus.in_func == func_ars);

   // One-bit shift of the working register according to the latched FuncCode
   always_comb begin
      shifted = work;
      case (func)
         func_lls, func_als: shifted = {work[data_width-2:0], 1'b0};
         func_lrs:           shifted = {1'b0, work[data_width-1:1]};
         func_ars:           shifted = {work[data_width-1], work[data_width-1:1]};
         default:            shifted = work;
      endcase
   end

   // Next-state, datapath update and handshake outputs
   always_comb begin
      state_next = state;
      work_next  = work;
      count_next = count;
      func_next  = func;
      ovf_next   = ovf;

      bus.in_ready     = (state == IDLE);
      bus.out_valid    = (state == DONE);
      bus.out_c        = work;
      bus.out_overflow = ovf;

      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               func_next  = bus.in_func;
               work_next  = bus.in_a;
               count_next = amt_clamped;
               ovf_next   = 1'b0;
               if (!func_ok) begin
                  // Unsupported code: pass the operand through and flag it
                  ovf_next   = 1'b1;
                  state_next = DONE;
               end else if (amt_clamped == '0) begin
                  state_next = DONE;
               end else begin
                  state_next = SHIFT;
               end
            end
         end

         SHIFT: begin
            work_next  = shifted;
            count_next = count - cnt_w'(1);
`ifdef ALU_SHIFT_ALS_OVF_EN
            // A differing top pair means this step flips the sign
            if ((func == func_als) && (work[data_width-1] != work[data_width-2])) begin
               ovf_next = 1'b1;
            end
`endif
            if (count == cnt_w'(1)) begin
               state_next = DONE;
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register; reset abandons any request in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Working register, step counter, latched FuncCode and error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         work  <= '0;
         count <= '0;
         func  <= '0;
         ovf   <= 1'b0;
      end else begin
         work  <= work_next;
         count <= count_next;
         func  <= func_next;
         ovf   <= ovf_next;
      end
   end

endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: scoreboard bench for alu_shift_seq. A driver issues
// directed and random requests and queues the expected result computed from
// plain arithmetic; a monitor pops and compares on every output transfer.
module tb_alu_shift_seq;

   localparam int DW = 16;
   localparam int AW = 5;

   localparam logic [3:0] LLS = 4'b0100;
   localparam logic [3:0] LRS = 4'b0101;
   localparam logic [3:0] ALS = 4'b0110;
   localparam logic [3:0] ARS = 4'b0111;

`ifdef ALU_SHIFT_ALS_OVF_EN
   localparam bit ALS_OVF_EN = 1'b1;
`else
   localparam bit ALS_OVF_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   ready_mode = 0;

   int checks = 0;
   int errors = 0;
   int result_id = 0;

   logic [DW-1:0] exp_c_q[$];
   logic          exp_o_q[$];

   logic          held = 1'b0;
   logic [DW-1:0] held_c;
   logic          held_o;

   alu_shift_seq_if #(.data_width(DW), .amt_width(AW)) bus ();

   alu_shift_seq #(.data_width(DW), .amt_width(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference result: the whole shift done at once with plain arithmetic
   function automatic logic [DW-1:0] modelC(input logic [3:0] f, input logic [DW-1:0] a, input int amt);
      int     k;
      longint sa;
      k  = (amt >= DW) ? DW : amt;
      sa = longint'($signed(a));
      case (f)
         LLS, ALS: return (k >= DW) ? '0 : DW'(a << k);
         LRS:      return (k >= DW) ? '0 : DW'(a >> k);
         ARS:      return DW'(sa >>> k);
         default:  return a;
      endcase
   endfunction

   // Reference flag: ALS overflows when a*2^k leaves the signed range
   function automatic logic modelO(input logic [3:0] f, input logic [DW-1:0] a, input int amt);
      int     k;
      longint p;
      longint maxv;
      longint minv;
      k = (amt >= DW) ? DW : amt;
      if (!(f == LLS || f == LRS || f == ALS || f == ARS)) return 1'b1;
      if (f != ALS || !ALS_OVF_EN) return 1'b0;
      p    = longint'($signed(a)) * (longint'(1) << k);
      maxv = (longint'(1) << (DW - 1)) - 1;
      minv = -(longint'(1) << (DW - 1));
      return (p > maxv) || (p < minv);
   endfunction

   // Compare one transferred result against the expected pair
   task automatic checkOutput(input int id, input logic [DW-1:0] act_c, input logic act_o,
                              input logic [DW-1:0] exp_c, input logic exp_o);
      checks++;
      if (act_c !== exp_c || act_o !== exp_o) begin
         errors++;
         $display("[TB] FAIL result #%0d: got out_c=%h out_overflow=%b, expected out_c=%h out_overflow=%b",
                  id, act_c, act_o, exp_c, exp_o);
      end
   endtask

   // Consumer ready: always, random, or held low
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = 1'($urandom_range(0, 1));
         default: bus.out_ready = 1'b0;
      endcase
   end

   // Monitor: handshake sanity, stall stability and scoreboard pop
   always @(negedge clk) begin
      if (reset) begin
         held = 1'b0;
      end else begin
         if (bus.out_valid === 1'b1) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
               errors++;
               $display("[TB] FAIL ready_while_valid: in_ready=%b, expected 0", bus.in_ready);
            end
         end
         if (held) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_c !== held_c || bus.out_overflow !== held_o) begin
               errors++;
               $display("[TB] FAIL stall_hold: out_valid=%b out_c=%h out_overflow=%b, expected 1 %h %b",
                        bus.out_valid, bus.out_c, bus.out_overflow, held_c, held_o);
            end
         end
         held   = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
         held_c = bus.out_c;
         held_o = bus.out_overflow;
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_c_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output: out_c=%h with nothing pending", bus.out_c);
            end else begin
               checkOutput(result_id, bus.out_c, bus.out_overflow, exp_c_q.pop_front(), exp_o_q.pop_front());
               result_id++;
            end
         end
      end
   end

   // Issue one request, queue its expected result and check its latency
   task automatic applyStimulus(input logic [3:0] f, input logic [DW-1:0] a, input logic [AW-1:0] amt);
      int k;
      int lat;
      int guard;
      bit ok;
      k  = (int'(amt) >= DW) ? DW : int'(amt);
      ok = (f == LLS || f == LRS || f == ALS || f == ARS);
      bus.in_valid = 1'b1;
      bus.in_func  = f;
      bus.in_a     = a;
      bus.in_amt   = amt;
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (bus.in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready=%b, expected 1", bus.in_ready);
         bus.in_valid = 1'b0;
         return;
      end
      exp_c_q.push_back(modelC(f, a, int'(amt)));
      exp_o_q.push_back(modelO(f, a, int'(amt)));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_a     = DW'($urandom);
      bus.in_amt   = AW'($urandom);
      bus.in_func  = 4'($urandom);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat != (ok ? k + 1 : 1)) begin
         errors++;
         $display("[TB] FAIL latency: got %0d cycles, expected %0d", lat, ok ? k + 1 : 1);
      end
   endtask

   // Wait until every queued result has been delivered and the DUT is idle
   task automatic waitIdle();
      int guard;
      guard = 0;
      while ((exp_c_q.size() != 0 || bus.in_ready !== 1'b1) && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checks++;
      if (exp_c_q.size() != 0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL drain: %0d results pending, in_ready=%b", exp_c_q.size(), bus.in_ready);
      end
   endtask

   // Main sequence: reset, directed cases, stall, mid-shift reset, random
   initial begin
      int r;
      logic [3:0] f;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_amt   = '0;
      bus.in_func  = '0;
      reset        = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_c !== '0 || bus.out_overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b out_c=%h out_overflow=%b, expected 1 0 0000 0",
                  bus.in_ready, bus.out_valid, bus.out_c, bus.out_overflow);
      end

      applyStimulus(LLS, 16'h0001, 5'd4);
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ready_in_done: in_ready=%b, expected 0", bus.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ready_after_transfer: in_ready=%b out_valid=%b, expected 1 0",
                  bus.in_ready, bus.out_valid);
      end

      applyStimulus(ARS, 16'h8000, 5'd3);
      applyStimulus(LRS, 16'h8000, 5'd3);
      applyStimulus(ARS, 16'h8000, 5'd20);
      applyStimulus(LLS, 16'h8000, 5'd20);
      applyStimulus(LLS, 16'h1234, 5'd0);
      applyStimulus(4'hF, 16'h00AB, 5'd7);
      applyStimulus(ALS, 16'h4000, 5'd1);
      applyStimulus(ALS, 16'h0001, 5'd2);
      applyStimulus(ALS, 16'hC000, 5'd31);
      waitIdle();

      @(negedge clk);
      ready_mode = 2;
      applyStimulus(LRS, 16'h00F0, 5'd2);
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_func  = LLS;
         bus.in_a     = 16'hDEAD;
         bus.in_amt   = 5'd1;
         @(posedge clk);
         #1;
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_ready: in_ready=%b out_valid=%b, expected 0 1", bus.in_ready, bus.out_valid);
         end
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      ready_mode = 0;
      waitIdle();

      bus.in_valid = 1'b1;
      bus.in_func  = LLS;
      bus.in_a     = 16'h00FF;
      bus.in_amt   = 5'd10;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset: in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
      end
      r = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b0) r++;
      end
      checks++;
      if (r != 0) begin
         errors++;
         $display("[TB] FAIL discarded_request: out_valid seen %0d cycles, expected 0", r);
      end

      @(negedge clk);
      ready_mode = 1;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1:    f = LLS;
            2, 3:    f = LRS;
            4, 5, 9: f = ALS;
            6, 7:    f = ARS;
            default: f = 4'($urandom_range(8, 15));
         endcase
         applyStimulus(f, DW'($urandom), AW'($urandom_range(0, 31)));
      end
      @(negedge clk);
      ready_mode = 0;
      waitIdle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog against a wedged handshake
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
